// File: rtl/autocorr.sv
// Autocorrelation front end: computes lags r[0..10] of one speech frame and
// streams them into the r register file, pulsing done to launch Levinson.
module autocorr #(
  parameter int N     = 240,
  parameter int AW    = 10,
  parameter int SHIFT = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic [AW-1:0]      x_rsel_a_o,
  output logic [AW-1:0]      x_rsel_b_o,
  input  logic signed [15:0] x_r_a_i,
  input  logic signed [15:0] x_r_b_i,
  output logic [10:0]        r_wsel_o,
  output logic [31:0]        r_w_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_e;

  localparam logic [AW-1:0]      LAST_N  = AW'(N - 1);
  localparam logic [3:0]         MAX_LAG = 4'd10;
  localparam logic signed [47:0] SAT_MAX = 48'sd2147483647;
  localparam logic signed [47:0] SAT_MIN = -48'sd2147483648;

  state_e             state_q;
  logic [3:0]         k_q;
  logic [AW-1:0]      n_q;
  logic signed [47:0] acc_q;
  logic               valid_q;
  logic [10:0]        r_wsel_q;
  logic [31:0]        r_w_q;
  logic               busy_q;
  logic               done_q;

  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] prod;
  logic signed [47:0] acc_d;
  logic signed [47:0] shifted;
  logic [31:0]        sat_val;

  // valid_q marks the cycle in which data for the previous address pair arrives
  always_comb begin
    a_ext   = {{16{x_r_a_i[15]}}, x_r_a_i};
    b_ext   = {{16{x_r_b_i[15]}}, x_r_b_i};
    prod    = a_ext * b_ext;
    acc_d   = valid_q ? (acc_q + {{16{prod[31]}}, prod}) : acc_q;
    shifted = acc_d >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = 32'h7FFF_FFFF;
    end else if (shifted < SAT_MIN) begin
      sat_val = 32'h8000_0000;
    end else begin
      sat_val = shifted[31:0];
    end
  end

  always_comb begin
    x_rsel_a_o = '0;
    x_rsel_b_o = '0;
    if (state_q == ISSUE) begin
      x_rsel_a_o = n_q;
      x_rsel_b_o = n_q - AW'(k_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      r_wsel_q <= '0;
      r_w_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= (state_q == ISSUE);
      acc_q   <= acc_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ISSUE;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (n_q == LAST_N) begin
            state_q <= DRAIN;
          end else begin
            n_q <= n_q + 1'b1;
          end
        end
        // The last product lands here, so the saturated lag is taken from acc_d
        DRAIN: begin
          state_q  <= WRITE;
          r_wsel_q <= 11'd1 << k_q;
          r_w_q    <= sat_val;
        end
        WRITE: begin
          r_wsel_q <= '0;
          r_w_q    <= '0;
          acc_q    <= '0;
          if (k_q < MAX_LAG) begin
            state_q <= ISSUE;
            k_q     <= k_q + 4'd1;
            n_q     <= AW'(k_q) + AW'(1);
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_wsel_o = r_wsel_q;
  assign r_w_o    = r_w_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_autocorr.sv
// Directed-vector bench for autocorr: one instance with SHIFT=8, one with SHIFT=0,
// sharing a registered-read sample memory model.
`timescale 1ns/1ps
module tb_autocorr;

  localparam int N  = 240;
  localparam int AW = 10;
  localparam int FRAME_CYCLES = 11 * N - 33 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start8;
  logic start0;

  logic [AW-1:0]      a8, b8, a0, b0;
  logic signed [15:0] xa8, xb8, xa0, xb0;
  logic [10:0]        wsel8, wsel0;
  logic [31:0]        rw8, rw0;
  logic               busy8, busy0, done8, done0;

  autocorr #(.N(N), .AW(AW), .SHIFT(8)) u8 (
    .clk_i(clk), .reset_i(reset), .start_i(start8),
    .x_rsel_a_o(a8), .x_rsel_b_o(b8), .x_r_a_i(xa8), .x_r_b_i(xb8),
    .r_wsel_o(wsel8), .r_w_o(rw8), .busy_o(busy8), .done_o(done8)
  );

  autocorr #(.N(N), .AW(AW), .SHIFT(0)) u0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0),
    .x_rsel_a_o(a0), .x_rsel_b_o(b0), .x_r_a_i(xa0), .x_r_b_i(xb0),
    .r_wsel_o(wsel0), .r_w_o(rw0), .busy_o(busy0), .done_o(done0)
  );

  logic signed [15:0] mem [0:1023];

  always @(posedge clk) begin
    xa8 <= mem[a8];
    xb8 <= mem[b8];
    xa0 <= mem[a0];
    xb0 <= mem[b0];
  end

  int sel = 0;
  logic [10:0]   selWsel;
  logic [31:0]   selRw;
  logic          selBusy, selDone;
  logic [AW-1:0] selA, selB;

  always_comb begin
    selWsel = (sel != 0) ? wsel0 : wsel8;
    selRw   = (sel != 0) ? rw0   : rw8;
    selBusy = (sel != 0) ? busy0 : busy8;
    selDone = (sel != 0) ? done0 : done8;
    selA    = (sel != 0) ? a0    : a8;
    selB    = (sel != 0) ? b0    : b8;
  end

  // Register-file model plus running strobe/order/done counters
  logic [31:0] rf [0:10];
  int strobes  = 0;
  int seqErrs  = 0;
  int doneSeen = 0;
  int nextK    = 0;

  always @(negedge clk) begin
    if (reset) begin
      nextK = 0;
    end else begin
      if (selWsel != 11'd0) begin
        strobes++;
        if (selWsel != (11'd1 << nextK)) seqErrs++;
        for (int k = 0; k < 11; k++) if (selWsel[k]) rf[k] = selRw;
        nextK++;
      end
      if (selDone) begin
        doneSeen++;
        nextK = 0;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic loadPattern(input int p);
    for (int i = 0; i < 1024; i++) begin
      case (p)
        0: mem[i] = (i == 0) ? 16'h4000 : 16'h0000;
        1: mem[i] = 16'h1000;
        2: mem[i] = 16'h0000;
        3: mem[i] = 16'h8000;
        default: mem[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8001;
      endcase
    end
    if (p == 2) begin
      mem[0]  = 16'h0100;
      mem[1]  = 16'hFE00;
      mem[2]  = 16'h0300;
      mem[10] = 16'hFFFF;
    end
  endtask

  // Cycle 1 is the one right after the start edge; returns the cycle done is seen
  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!selDone && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("done seen", {31'd0, selDone}, 32'd1);
    checkOutput("busy low at done", {31'd0, selBusy}, 32'd0);
  endtask

  task automatic applyStimulus(input int s, input bit hold, output int cyc);
    sel = s;
    @(negedge clk);
    if (s != 0) start0 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start8 = 1'b0;
      start0 = 1'b0;
    end
    checkOutput("busy after start", {31'd0, selBusy}, 32'd1);
    waitDone(cyc);
  endtask

  typedef struct {
    string             name;
    int                pattern;
    int                sel;
    logic [10:0][31:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic checkLags(input string name, input logic [10:0][31:0] exp);
    for (int k = 0; k < 11; k++) begin
      checkOutput($sformatf("%s r[%0d]", name, k), rf[k], exp[k]);
    end
  endtask

  initial begin
    int cyc;
    int s0, e0, d0;

    vecs[0].name = "impulse";     vecs[0].pattern = 0; vecs[0].sel = 0; vecs[0].exp = '0;
    vecs[0].exp[0] = 32'h0010_0000;
    vecs[1].name = "constant";    vecs[1].pattern = 1; vecs[1].sel = 0;
    for (int k = 0; k < 11; k++) vecs[1].exp[k] = 32'(240 - k) << 16;
    vecs[2].name = "sparse";      vecs[2].pattern = 2; vecs[2].sel = 0; vecs[2].exp = '0;
    vecs[2].exp[0]  = 32'h0000_0E00;
    vecs[2].exp[1]  = 32'hFFFF_F800;
    vecs[2].exp[2]  = 32'h0000_0300;
    vecs[2].exp[8]  = 32'hFFFF_FFFD;
    vecs[2].exp[9]  = 32'h0000_0002;
    vecs[2].exp[10] = 32'hFFFF_FFFF;
    vecs[3].name = "sat_min_all"; vecs[3].pattern = 3; vecs[3].sel = 1;
    for (int k = 0; k < 11; k++) vecs[3].exp[k] = 32'h7FFF_FFFF;
    vecs[4].name = "sat_alt";     vecs[4].pattern = 4; vecs[4].sel = 1;
    for (int k = 0; k < 11; k++) vecs[4].exp[k] = (k % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;

    reset  = 1'b1;
    start8 = 1'b0;
    start0 = 1'b0;
    loadPattern(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset wsel", {21'd0, wsel8 | wsel0}, 32'd0);
    checkOutput("reset rw", rw8 | rw0, 32'd0);
    checkOutput("reset busy/done", {30'd0, busy8 | busy0, done8 | done0}, 32'd0);
    checkOutput("reset addr", {12'd0, a8 | a0, b8 | b0}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    s0 = strobes;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle strobes", 32'(strobes - s0), 32'd0);
    checkOutput("idle busy", {31'd0, busy8}, 32'd0);

    // Reset outranks a start sampled on the same edge
    @(negedge clk);
    reset  = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset beats start", {31'd0, busy8}, 32'd0);
    start8 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      loadPattern(vecs[v].pattern);
      s0 = strobes;
      e0 = seqErrs;
      applyStimulus(vecs[v].sel, 1'b0, cyc);
      checkOutput({vecs[v].name, " done cycle"}, 32'(cyc), 32'(FRAME_CYCLES));
      checkOutput({vecs[v].name, " strobes"}, 32'(strobes - s0), 32'd11);
      checkOutput({vecs[v].name, " order"}, 32'(seqErrs - e0), 32'd0);
      checkLags(vecs[v].name, vecs[v].exp);
      repeat (3) @(posedge clk);
    end

    // Reset 500 cycles into an impulse frame, then a clean restart
    loadPattern(0);
    sel = 0;
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (499) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset wsel", {21'd0, wsel8}, 32'd0);
    checkOutput("midreset busy/done", {30'd0, busy8, done8}, 32'd0);
    checkOutput("midreset addr", {12'd0, selA, selB}, 32'd0);
    s0 = strobes;
    d0 = doneSeen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("midreset no strobes", 32'(strobes - s0), 32'd0);
    checkOutput("midreset no done", 32'(doneSeen - d0), 32'd0);
    s0 = strobes;
    e0 = seqErrs;
    applyStimulus(0, 1'b0, cyc);
    checkOutput("restart done cycle", 32'(cyc), 32'(FRAME_CYCLES));
    checkOutput("restart strobes", 32'(strobes - s0), 32'd11);
    checkOutput("restart order", 32'(seqErrs - e0), 32'd0);
    checkLags("restart", vecs[0].exp);
    repeat (3) @(posedge clk);

    // Start held high: ignored mid-frame, relaunches a frame only via IDLE
    loadPattern(1);
    s0 = strobes;
    e0 = seqErrs;
    applyStimulus(0, 1'b1, cyc);
    checkOutput("held first done cycle", 32'(cyc), 32'(FRAME_CYCLES));
    @(posedge clk);
    #1;
    checkOutput("held DONE busy", {31'd0, busy8}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held relaunch busy", {31'd0, busy8}, 32'd1);
    start8 = 1'b0;
    waitDone(cyc);
    checkOutput("held second done cycle", 32'(cyc), 32'(FRAME_CYCLES));
    checkOutput("held strobes", 32'(strobes - s0), 32'd22);
    checkOutput("held order", 32'(seqErrs - e0), 32'd0);
    checkLags("held", vecs[1].exp);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/autocorr.md
# autocorr

Computes the 11 autocorrelation lags r[0..10] of one windowed speech frame and writes them into the 32x11 r register file, one lag per one-hot write strobe. Sits directly upstream of the Levinson-Durbin stage. Its one-cycle done pulse is the start/reset pulse that launches Levinson.

## Interface
- N, 240: frame length in samples; 12 ≤ N ≤ 1024.
- AW, 10: sample address width; must satisfy 2^AW ≥ N.
- SHIFT, 8: arithmetic right shift applied to each accumulator before saturation.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a frame; sampled only in IDLE.
- x_rsel_a  out  AW  sample read address, port A (index n).
- x_rsel_b  out  AW  sample read address, port B (index n-k).
- x_r_a  in  16  signed Q1.15 sample for port A; valid one cycle after the address.
- x_r_b  in  16  signed Q1.15 sample for port B; same latency.
- r_wsel  out  11  one-hot write select into the r register file; bit k means lag k.
- r_w  out  32  lag value, two's complement; valid while r_wsel ≠ 0.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after r[10] is written.

## Operation
- r[k] = sat32( (Σ_{n=k}^{N-1} x[n]·x[n-k]) >>> SHIFT ), for k = 0..10.
- Products are 16x16 signed, giving 32-bit results.
- The accumulator is 48-bit signed and cleared at the start of each lag.
- The >>> is arithmetic. sat32 clamps to 0x80000000..0x7FFFFFFF.
- States:
  - IDLE: wait for start.
  - ISSUE: drive address pair (n, n-k) for n = k..N-1, one pair per cycle.
  - DRAIN: one cycle; accumulate the final product.
  - WRITE: one cycle; r_wsel = 1<<k, r_w = sat value.
  - DONE: one cycle; done = 1.
- Transitions:
  - IDLE → ISSUE on start (k=0, n=0).
  - ISSUE → DRAIN when n = N-1 is issued.
  - DRAIN → WRITE.
  - WRITE → ISSUE with k+1, n = k+1, acc = 0, if k < 10; else WRITE → DONE.
  - DONE → IDLE.
- Accumulate rule: the product of x_r_a·x_r_b is added on the edge after the data arrives. This is the data-valid cycle following each ISSUE cycle, including the DRAIN cycle.
- Addresses are combinational from the registered n/k counters and equal 0 outside ISSUE.
- r_wsel, r_w, done and busy are registered.
- Lag writes occur in ascending k order, exactly once each per frame.

## Timing
- Reset value of every output is 0: x_rsel_a, x_rsel_b, r_wsel, r_w, busy, done. State returns to IDLE, k = n = acc = 0.
- Edge E0 samples start = 1 in IDLE. Address pair (0,0) is driven in the cycle after E0.
- Per lag k: (N-k) ISSUE + 1 DRAIN + 1 WRITE cycles.
- A full frame is 11N − 33 cycles from E0 to the last WRITE: 2607 cycles for N = 240. done is high in the following cycle.
- busy goes high the cycle after E0 and low in the same cycle done goes high.
- start while busy or in DONE is ignored.
- start held high causes a new frame to begin from IDLE after DONE. There is no implicit repeat within a frame.
- Reset asserted mid-frame:
  - At the next edge, all outputs go to 0.
  - No further r_wsel strobes are issued; done is not pulsed.
  - Lags already written remain in the register file.
- Reset and start high on the same edge: reset wins.
- The upstream sample memory must not change during busy.

## Test plan
- Reset: hold reset 2 cycles → all outputs 0, no r_wsel activity for 20 cycles with start = 0.
- Impulse: x[0] = 0x4000, all other samples 0, SHIFT = 8.
  - r[0] = 0x00100000, r[1..10] = 0.
  - done exactly 2608 cycles after the start edge.
  - r_wsel sequence 0x001, 0x002, … 0x400.
- Constant: all x = 0x1000, SHIFT = 8 → r[k] = (240−k)·0x10000, i.e. r[0] = 0x00F00000, r[10] = 0x00E60000.
- Saturation: SHIFT = 0.
  - All x = 0x8000 → every r[k] = 0x7FFFFFFF.
  - Alternating x[n] = (−1)^n·0x7FFF → r[0] = 0x7FFFFFFF, r[1] = 0x80000000.
- Reset mid-frame: assert reset 500 cycles after start.
  - r_wsel = 0 from the next edge; no done pulse.
  - A fresh start then produces the full impulse result.
- Chained with Levinson: done drives Levinson's start. Speech frame whose expected lags are r[0] = 0x11072150 and r[1] = 0x0FC15598 → register file matches the expected values, and Levinson writes a[1..10] after done.
